// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined MIPS immediate extension (sign/zero/upper/branch) with valid/ready handshake
// Ports: clk, rst_n (async active-low), flush (sync, drops all held entries),
//   in_valid/in_ready/in_imm/in_mode/in_tag upstream side,
//   out_valid/out_ready/out_data/out_tag downstream side.
// Build option: define IMM_EXT_SKID_EN for a two-entry skid buffer with a registered in_ready;
//   otherwise a single output register with in_ready = !out_valid || out_ready.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_params
    $error("imm_extend_pipe: need IN_W >= 2 and OUT_W >= IN_W + 2");
  end
  localparam int PAD = OUT_W - IN_W;
  logic [OUT_W-1:0] sx;
  logic [OUT_W-1:0] ext;
  assign sx = {{PAD{in_imm[IN_W-1]}}, in_imm};
  // branch mode keeps only the low OUT_W-2 bits of the sign extension, shifted up by 2
  assign ext = in_mode == 2'd0 ? sx :
               in_mode == 2'd1 ? {{PAD{1'b0}}, in_imm} :
               in_mode == 2'd2 ? {in_imm, {PAD{1'b0}}} :
                                 {sx[OUT_W-3:0], 2'b00};
`ifdef IMM_EXT_SKID_EN
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             acc;
  logic             drain;
  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_ready = !skid_valid;
  assign acc      = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  // occupancy: EMPTY = !out_valid, ONE = out_valid && !skid_valid, TWO = skid_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid) begin
      out_valid <= acc;
      if (acc) begin
        out_data <= ext;
        out_tag  <= in_tag;
      end
    end else if (!skid_valid) begin
      if (drain && !acc) out_valid <= 1'b0;
      else if (drain) begin
        out_data <= ext;
        out_tag  <= in_tag;
      end else if (acc) begin
        skid_valid <= 1'b1;
        skid_data  <= ext;
        skid_tag   <= in_tag;
      end
    end else if (drain) begin
      out_data   <= skid_data;
      out_tag    <= skid_tag;
      skid_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= ext;
        out_tag  <= in_tag;
      end
    end
  end
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed and randomised checks of imm_extend_pipe (16/32 and 12/20 instances)
module tb_imm_extend_pipe;
`ifdef IMM_EXT_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        v1 = 1'b0;
  logic        in_ready1;
  logic [11:0] imm1 = '0;
  logic [1:0]  mode1 = '0;
  logic        out_valid1;
  logic        out_ready1 = 1'b1;
  logic [19:0] out_data1;
  logic [4:0]  out_tag1;
  int          passed = 0;
  int          total = 0;
  logic        stress = 1'b0;
  logic        last_acc;
  int          nt;
  int          last_t;
  logic [4:0]  got[$];
  logic [36:0] q[$];
  logic [36:0] e;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag));

  imm_extend_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v1), .in_ready(in_ready1),
    .in_imm(imm1), .in_mode(mode1), .in_tag(in_tag), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_tag(out_tag1));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
    logic signed [31:0] s;
    s = $signed(imm);
    case (m)
      2'd0:    return s;
      2'd1:    return {16'h0000, imm};
      2'd2:    return {imm, 16'h0000};
      default: return s * 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    #1;
    last_acc = in_valid && in_ready;
    if (stress) begin
      if (out_valid && out_ready) begin
        chk("stress_q_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("stress_data", 64'(out_data), 64'(e[31:0]));
          chk("stress_tag", 64'(out_tag), 64'(e[36:32]));
        end
      end
      if (last_acc) q.push_back({in_tag, ref_ext(in_imm, in_mode)});
    end else if (out_valid && out_ready) got.push_back(out_tag);
    @(posedge clk);
    #1;
  endtask

  task automatic feed();
    tick();
    if (last_acc) nt++;
    if (nt > last_t) in_valid = 1'b0;
    else begin
      in_tag = 5'(nt);
      in_imm = 16'(nt);
    end
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] m, input logic [4:0] t, input logic [31:0] exp);
    in_valid = 1'b1;
    in_imm = imm;
    in_mode = m;
    in_tag = t;
    tick();
    chk("mode_valid", 64'(out_valid), 64'd1);
    chk("mode_data", 64'(out_data), 64'(exp));
    chk("mode_tag", 64'(out_tag), 64'(t));
  endtask

  initial begin
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h8001, 2'd0, 5'd1, 32'hFFFF8001);
    send(16'h8001, 2'd1, 5'd2, 32'h00008001);
    send(16'h8001, 2'd2, 5'd3, 32'h80010000);
    send(16'h8001, 2'd3, 5'd4, 32'hFFFE0004);
    send(16'h7FFF, 2'd3, 5'd5, 32'h0001FFFC);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    // back-pressure: tags 1..4 with out_ready low for three cycles
    got.delete();
    out_ready = 1'b0;
    in_mode = 2'd1;
    nt = 1;
    last_t = 4;
    in_valid = 1'b1;
    in_tag = 5'd1;
    in_imm = 16'd1;
    feed();
    chk("bp_ready_after_one", 64'(in_ready), 64'(SKID));
    chk("bp_data_stall1", 64'(out_data), 64'd1);
    feed();
    chk("bp_data_stall2", 64'(out_data), 64'd1);
    chk("bp_tag_stall2", 64'(out_tag), 64'd1);
    feed();
    chk("bp_data_stall3", 64'(out_data), 64'd1);
    chk("bp_tag_stall3", 64'(out_tag), 64'd1);
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    repeat (8) feed();
    chk("bp_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("bp_order", 64'(got[i]), 64'(i + 1));
    // flush with entries held and a simultaneous input carrying tag 9
    got.delete();
    out_ready = 1'b0;
    nt = 5;
    last_t = 6;
    in_valid = 1'b1;
    in_tag = 5'd5;
    in_imm = 16'd5;
    feed();
    feed();
    chk("fl_held", 64'(out_valid), 64'd1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_tag = 5'd9;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_nothing_out", 64'(got.size()), 64'd0);
    // asynchronous reset while the stage is full
    out_ready = 1'b0;
    nt = 1;
    last_t = 2;
    in_valid = 1'b1;
    in_tag = 5'd1;
    in_imm = 16'h1234;
    feed();
    feed();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_data", 64'(out_data), 64'd0);
    chk("mrst_tag", 64'(out_tag), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_imm = 16'h8001;
    in_mode = 2'd0;
    in_tag = 5'd7;
    out_ready = 1'b1;
    #1;
    chk("mrst_not_yet", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("mrst_first_valid", 64'(out_valid), 64'd1);
    chk("mrst_first_tag", 64'(out_tag), 64'd7);
    chk("mrst_first_data", 64'(out_data), 64'hFFFF8001);
    tick();
    // 12-bit to 20-bit instance
    v1 = 1'b1;
    imm1 = 12'hFFF;
    mode1 = 2'd0;
    in_tag = 5'd3;
    tick();
    chk("sw_ready", 64'(in_ready1), 64'd1);
    chk("sw_sign", 64'(out_data1), 64'hFFFFF);
    chk("sw_tag", 64'(out_tag1), 64'd3);
    mode1 = 2'd2;
    tick();
    chk("sw_upper", 64'(out_data1), 64'hFFF00);
    chk("sw_valid", 64'(out_valid1), 64'd1);
    v1 = 1'b0;
    // random valid/ready stress against a reference queue
    stress = 1'b1;
    q.delete();
    repeat (3000) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_imm = 16'($urandom);
      in_mode = 2'($urandom_range(0, 3));
      in_tag = 5'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("stress_all_drained", 64'(q.size()), 64'd0);
    chk("stress_idle", 64'(out_valid), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
